demux16_1_seq: RTL and testbench
================================

# demux16_1_seq

Registered 1-to-16 demultiplexer with an auto-scan sequencer: the counterpart of the `mux16_1` selector. It takes a single serial data bit and deposits it into one of sixteen held output registers `y0`..`y15`. The target is either the externally supplied select `s3..s0` (manual mode) or an internal 4-bit scan counter that steps 0→15 (auto mode). It is the receive end of a mux/demux serialization link: a `mux16_1` scanned with selects 0..15 and fed into this block in auto mode reconstructs the original sixteen inputs.

## Interface
Parameters:
- `CLEAR_ON_START`, default 0. When 1, `start` also clears `y0`..`y15` to 0. When 0, outputs hold their values.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `i`  input  1  serial data bit.
- `valid_in`  input  1  `i` is valid this cycle; a write occurs only when this is 1.
- `mode`  input  1  0 = manual (select from `s3..s0`), 1 = auto (select from internal counter).
- `start`  input  1  1-cycle pulse; restarts the auto frame at index 0.
- `s0`, `s1`, `s2`, `s3`  input  1 each  manual select; `s3` is the MSB, index = {s3,s2,s1,s0}.
- `y0`..`y15`  output  1 each  registered demux outputs; each holds its value until rewritten.
- `cnt`  output  4  current auto-scan index, i.e. the next index to be written.
- `frame_done`  output  1  1-cycle pulse; the auto frame completed (index 15 written).

## Operation
- Reset (`rst`=1 at an edge): `y0`..`y15`=0, `cnt`=0, `frame_done`=0, internal `mode_q`=0. Reset overrides every other input in that cycle.
- Select index: `sel` = {s3,s2,s1,s0} when `mode`=0; `sel` = effective count when `mode`=1.
- Write: when `valid_in`=1, `y[sel]` <= `i`. All other `y` outputs hold. When `valid_in`=0, no `y` changes.
- Manual mode: `cnt` holds and `frame_done` stays 0. A select change with `valid_in`=0 has no effect on the outputs.
- Auto mode: effective count = 0 if (`start`=1 or mode changed this cycle), otherwise `cnt`. On a write, `cnt` <= effective count + 1, modulo 16 (15→0 wraps). With no write, `cnt` <= effective count.
- `frame_done` <= 1 exactly when an auto-mode write targets index 15; otherwise 0.
- Start:
  - `start`=1 forces the effective count to 0.
  - If `valid_in`=1 in the same cycle, the bit is written to `y0` and `cnt` becomes 1.
  - If `CLEAR_ON_START`=1, all `y` are cleared first and then the same-cycle write (if any) is applied, so `y0`=`i`.
  - `start` in manual mode has no effect unless `CLEAR_ON_START`=1, in which case it clears the outputs only.
- Mode switch: `mode_q` registers `mode` every cycle. A change (`mode`≠`mode_q`) restarts the scan at index 0 in that cycle, exactly as `start` does but without clearing outputs. A switch to manual leaves `cnt` reset to 0.
- Reset mid-frame: the partial frame is discarded (outputs zeroed), `cnt`=0, and no `frame_done` is issued.
- Invalid/X select never occurs by construction; all 16 indices are legal.

## Timing
- Write latency: one cycle. A bit presented with `valid_in`=1 at edge n is visible on `y[sel]` after edge n.
- `cnt` and `frame_done` are registered and update on the same edge as the write.
- `frame_done` is high for exactly the cycle following the index-15 write edge, together with `cnt`=0.
- Throughput: one bit per cycle in both modes. A full auto frame takes 16 valid cycles, which need not be contiguous; gaps hold `cnt`.
- Back-to-back frames: the next frame's index-0 write may occur in the cycle `frame_done` is high.
- No combinational path exists from any input to any output.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `valid_in`=1, `i`=1 → all `y`=0, `cnt`=0, `frame_done`=0 after release.
- Manual sweep: `mode`=0, `valid_in`=1, select 0..15 with `i` pattern 0,1,0,1,0,1,1,0,1,0,1,1,1,0,1,0 → {y15..y0} = 16'h5D6A, `cnt` stays 0, `frame_done` never pulses. Then set select=5, `i`=0, `valid_in`=0 → outputs unchanged.
- Auto frame with gaps: `mode`=1, pulse `start`, feed the same 16-bit pattern with `valid_in` deasserted on every 4th cycle → {y15..y0}=16'h5D6A. `frame_done` pulses exactly once, one cycle after the 16th valid bit, with `cnt`=0. `cnt` never advances during a gap.
- Loopback: scan a `mux16_1` with selects 0..15 and inputs 16'hA5C3, and feed its `y` into this block in auto mode → {y15..y0}=16'hA5C3 after 16 cycles.
- Restart and wrap:
  - Write 6 bits in auto mode → `cnt`=6.
  - Assert `start` and `valid_in` together with `i`=1 → `y0`=1, `cnt`=1, no `frame_done`.
  - Write 17 more bits → `frame_done` pulses once and `cnt`=2.
- Mode switch and mid-frame reset: mid-frame at `cnt`=9, toggle `mode` to 0 → `cnt`=0. Return to 1 and write 3 bits → `cnt`=3. Assert `rst` → all `y`=0, `cnt`=0. Repeat the start test with `CLEAR_ON_START`=1 → all `y` cleared except a same-cycle write to `y0`.

Source files
------------

// File: rtl/demux16_1_seq.sv
// demux16_1_seq: registered 1-to-16 demultiplexer with an auto-scan sequencer.
// A serial bit is deposited into one of sixteen held outputs, addressed either
// by the manual select {s3,s2,s1,s0} or by an internal 4-bit scan counter.
module demux16_1_seq #(
  parameter int unsigned CLEAR_ON_START = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i,
  input  logic       valid_in,
  input  logic       mode,
  input  logic       start,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       y4,
  output logic       y5,
  output logic       y6,
  output logic       y7,
  output logic       y8,
  output logic       y9,
  output logic       y10,
  output logic       y11,
  output logic       y12,
  output logic       y13,
  output logic       y14,
  output logic       y15,
  output logic [3:0] cnt,
  output logic       frame_done
);

  logic [15:0] y_q, y_next;
  logic [3:0]  cnt_q, cnt_next, eff_cnt, sel;
  logic        mode_q, fd_q, fd_next;
  logic        mode_chg, restart, clear;

  // Next-state: restart detection, target select, output write, scan counter
  always_comb begin
    mode_chg = mode ^ mode_q;
    restart  = start | mode_chg;
    eff_cnt  = restart ? '0 : cnt_q;
    sel      = mode ? eff_cnt : {s3, s2, s1, s0};
    clear    = start && (CLEAR_ON_START != 0);

    // Clear is applied first so a same-cycle write still lands in the target.
    y_next = clear ? '0 : y_q;
    if (valid_in) begin
      y_next[sel] = i;
    end

    if (mode) begin
      cnt_next = valid_in ? eff_cnt + 4'd1 : eff_cnt;
    end else begin
      cnt_next = mode_chg ? '0 : cnt_q;
    end

    fd_next = mode && valid_in && (eff_cnt == 4'd15);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      cnt_q  <= '0;
      fd_q   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      y_q    <= y_next;
      cnt_q  <= cnt_next;
      fd_q   <= fd_next;
      mode_q <= mode;
    end
  end

  assign {y15, y14, y13, y12, y11, y10, y9, y8,
          y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
  assign cnt        = cnt_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_demux16_1_seq.sv
// Self-checking bench for demux16_1_seq: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural reference model.
// Two instances share the stimulus: one with CLEAR_ON_START=0, one with 1.
module tb_demux16_1_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1, i = 1'b0, valid_in = 1'b0, mode = 1'b0, start = 1'b0;
  logic [3:0] s = '0;
  logic [15:0] ya, yb;
  logic [3:0] cnt_a, cnt_b;
  logic       fd_a, fd_b;

  int checks = 0;
  int errors = 0;
  int fd_pulses = 0;

  // reference model state
  logic [15:0] m_ya = '0, m_yb = '0;
  int          m_cnt = 0;
  logic        m_fd = 1'b0, m_mq = 1'b0;

  always #5 clk = ~clk;

  demux16_1_seq #(.CLEAR_ON_START(0)) dut_a (
    .clk(clk), .rst(rst), .i(i), .valid_in(valid_in), .mode(mode), .start(start),
    .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]),
    .y0(ya[0]), .y1(ya[1]), .y2(ya[2]), .y3(ya[3]), .y4(ya[4]), .y5(ya[5]),
    .y6(ya[6]), .y7(ya[7]), .y8(ya[8]), .y9(ya[9]), .y10(ya[10]), .y11(ya[11]),
    .y12(ya[12]), .y13(ya[13]), .y14(ya[14]), .y15(ya[15]),
    .cnt(cnt_a), .frame_done(fd_a)
  );

  demux16_1_seq #(.CLEAR_ON_START(1)) dut_b (
    .clk(clk), .rst(rst), .i(i), .valid_in(valid_in), .mode(mode), .start(start),
    .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]),
    .y0(yb[0]), .y1(yb[1]), .y2(yb[2]), .y3(yb[3]), .y4(yb[4]), .y5(yb[5]),
    .y6(yb[6]), .y7(yb[7]), .y8(yb[8]), .y9(yb[9]), .y10(yb[10]), .y11(yb[11]),
    .y12(yb[12]), .y13(yb[13]), .y14(yb[14]), .y15(yb[15]),
    .cnt(cnt_b), .frame_done(fd_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural rules: which slot is targeted, what the counter does next.
  task automatic model_update(input logic r, v, md, st, input logic [3:0] sl,
                              input logic d);
    int   idx;
    logic switched;
    if (r) begin
      m_ya = '0; m_yb = '0; m_cnt = 0; m_fd = 1'b0; m_mq = 1'b0;
      return;
    end
    switched = (md != m_mq);
    if (md) idx = (st || switched) ? 0 : m_cnt;
    else    idx = int'(sl);
    if (st) m_yb = '0;
    if (v) begin
      m_ya[idx] = d;
      m_yb[idx] = d;
    end
    m_fd = md && v && (idx == 15);
    if (md)            m_cnt = v ? (idx + 1) % 16 : idx;
    else if (switched) m_cnt = 0;
    m_mq = md;
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge, compare.
  task automatic step(input logic r, v, md, st, input logic [3:0] sl, input logic d);
    rst = r; valid_in = v; mode = md; start = st; s = sl; i = d;
    model_update(r, v, md, st, sl, d);
    @(posedge clk);
    #1;
    if (fd_a) fd_pulses++;
    chk("model_y_a",   int'(ya),    int'(m_ya));
    chk("model_y_b",   int'(yb),    int'(m_yb));
    chk("model_cnt_a", int'(cnt_a), m_cnt);
    chk("model_cnt_b", int'(cnt_b), m_cnt);
    chk("model_fd_a",  int'(fd_a),  int'(m_fd));
    chk("model_fd_b",  int'(fd_b),  int'(m_fd));
  endtask

  typedef struct {
    logic r, v, md, st;
    logic [3:0] sl;
    logic d;
    logic [15:0] ey;
    logic [3:0] ec;
    logic ef;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [15:0] pat, mux_in;
    logic        md_r;
    int k, c;

    pat    = 16'h5D6A;
    mux_in = 16'hA5C3;

    // reset with valid data present, then manual sweep, then a select change without valid
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 4'd0, 1'b0};
    for (int n = 0; n < 16; n++) begin
      logic [15:0] mask;
      mask = 16'((32'd2 << n) - 1);
      tbl[2 + n] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'(n), pat[n], pat & mask, 4'd0, 1'b0};
    end
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 16'h5D6A, 4'd0, 1'b0};

    @(negedge clk);
    for (int n = 0; n < 19; n++) begin
      step(tbl[n].r, tbl[n].v, tbl[n].md, tbl[n].st, tbl[n].sl, tbl[n].d);
      chk($sformatf("tbl%0d_y", n),   int'(ya),    int'(tbl[n].ey));
      chk($sformatf("tbl%0d_cnt", n), int'(cnt_a), int'(tbl[n].ec));
      chk($sformatf("tbl%0d_fd", n),  int'(fd_a),  int'(tbl[n].ef));
    end

    // auto frame with every 4th cycle idle
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    chk("gap_start_cnt", int'(cnt_a), 0);
    fd_pulses = 0;
    k = 0; c = 0;
    while (k < 16) begin
      if (c % 4 == 3) begin
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("gap_hold_cnt", int'(cnt_a), k);
        chk("gap_no_fd", int'(fd_a), 0);
      end else begin
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, pat[k]);
        k++;
        chk("gap_cnt", int'(cnt_a), k % 16);
        chk("gap_fd", int'(fd_a), (k == 16) ? 1 : 0);
      end
      c++;
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("gap_fd_after", int'(fd_a), 0);
    chk("gap_y", int'(ya), 16'h5D6A);
    chk("gap_fd_pulses", fd_pulses, 1);

    // loopback from a mux scanned 0..15, restarting with start on the first bit
    for (int n = 0; n < 16; n++) begin
      logic [3:0] msel;
      msel = 4'(n);
      step(1'b0, 1'b1, 1'b1, (n == 0), 4'd0, mux_in[msel]);
    end
    chk("loop_y", int'(ya), 16'hA5C3);
    chk("loop_cnt", int'(cnt_a), 0);
    chk("loop_fd", int'(fd_a), 1);

    // restart mid-frame then wrap
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'($urandom));
    chk("rw_cnt6", int'(cnt_a), 6);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
    chk("rw_y0", int'(ya[0]), 1);
    chk("rw_cnt1", int'(cnt_a), 1);
    chk("rw_no_fd", int'(fd_a), 0);
    chk("rw_clear_y", int'(yb), 16'h0001);
    fd_pulses = 0;
    for (int n = 0; n < 17; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'($urandom));
    chk("rw_fd_pulses", fd_pulses, 1);
    chk("rw_cnt2", int'(cnt_a), 2);

    // mode switch mid-frame, then reset mid-frame
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    for (int n = 0; n < 9; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    chk("ms_cnt9", int'(cnt_a), 9);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    chk("ms_manual_cnt0", int'(cnt_a), 0);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    chk("ms_cnt3", int'(cnt_a), 3);
    chk("ms_y", int'(ya), 16'h01FF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    chk("rst_y_a", int'(ya), 0);
    chk("rst_y_b", int'(yb), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_fd", int'(fd_a), 0);

    // start in manual mode: clears only the CLEAR_ON_START instance, counter untouched
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    chk("man_start_y_a", int'(ya), 16'h0200);
    chk("man_start_y_b", int'(yb), 16'h0000);
    chk("man_start_cnt", int'(cnt_a), 0);

    // randomized traffic against the model
    md_r = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 29) == 0) md_r = ~md_r;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), md_r,
           ($urandom_range(0, 19) == 0), 4'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
